// File: rtl/inst_fetch_buf_pkg.sv
// Shared fetch-stage constants and FSM state encodings for inst_fetch_buf.
package inst_fetch_buf_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;

  // DISCARD: a request is still on the bus but its data belongs to a flushed path.
  localparam logic [1:0] IF_IDLE    = 2'd0;
  localparam logic [1:0] IF_WAIT    = 2'd1;
  localparam logic [1:0] IF_DISCARD = 2'd2;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// fetch_fifo: DEPTH x W synchronous FIFO with push, pop, clear and a combinational head.
// Clear has priority over push/pop and realigns the read pointer onto the write pointer.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_dat,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch stage: single-outstanding req/ack fetch into a FIFO feeding ID.
// Optional IF_BYPASS_EN forwards returning data straight to ID when the FIFO is empty.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = InstAddrBus,
  parameter int IW    = InstBus
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          pc_ce_i,
  input  logic          flush_i,
  output logic          stallreq_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_ack_i,
  input  logic [IW-1:0] mem_data_i,
  output logic          id_valid_o,
  input  logic          id_ready_i,
  output logic [AW-1:0] id_pc_o,
  output logic [IW-1:0] id_inst_o
);

  localparam int CW = cnt_width(DEPTH);

  logic [1:0]       r_state;
  logic [CW-1:0]    w_count;
  logic [AW+IW-1:0] w_head;
  logic             w_space;
  logic             w_issue;
  logic             w_wait_ack;
  logic             w_fifo_vld;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  assign w_wait_ack = (r_state == IF_WAIT) && mem_ack_i;

  // A pop in the same cycle is not credited; the slot it frees is seen next cycle.
  always_comb begin
    w_space = 1'b0;
    case (r_state)
      IF_IDLE:    w_space = (w_count < CW'(DEPTH));
      IF_WAIT:    w_space = (w_count < CW'(DEPTH - 1));
      IF_DISCARD: w_space = (w_count < CW'(DEPTH));
      default:    w_space = 1'b0;
    endcase
  end

  assign w_issue = (pc_ce_i == ChipEnable) && !flush_i && w_space &&
                   ((r_state == IF_IDLE) ||
                    (((r_state == IF_WAIT) || (r_state == IF_DISCARD)) && mem_ack_i));

  // The PC advances in exactly the cycle its address is captured, or on a branch.
  always_comb begin
    stallreq_o = NoStop;
    if ((rst == RstEnable) || (!w_issue && !flush_i)) stallreq_o = Stop;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state    <= IF_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      case (r_state)
        IF_IDLE: begin
          if (w_issue) begin
            r_state    <= IF_WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= pc_i;
          end
        end
        IF_WAIT, IF_DISCARD: begin
          if (mem_ack_i) begin
            if (w_issue) begin
              r_state    <= IF_WAIT;
              mem_addr_o <= pc_i;
            end else begin
              r_state   <= IF_IDLE;
              mem_req_o <= 1'b0;
            end
          end else if (flush_i) begin
            // The bus forbids withdrawing req, so the stale response is swallowed later.
            r_state <= IF_DISCARD;
          end
        end
        default: begin
          r_state   <= IF_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_BYPASS_EN
  assign w_bypass = (w_count == '0) && w_wait_ack && !flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_vld = (w_count != '0);
  assign w_push     = w_wait_ack && !flush_i && !(w_bypass && id_ready_i);
  assign w_pop      = w_fifo_vld && id_ready_i && !flush_i;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + IW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_dat   ({mem_addr_o, mem_data_i}),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    id_valid_o = w_fifo_vld || w_bypass;
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (w_bypass) begin
      id_pc_o   = mem_addr_o;
      id_inst_o = mem_data_i;
    end else if (w_fifo_vld) begin
      id_pc_o   = w_head[AW+IW-1:IW];
      id_inst_o = w_head[IW-1:0];
    end
  end

endmodule

// File: doc/inst_fetch_buf.md
Name: inst_fetch_buf

Overview:
- Instruction-fetch stage between the PC register and the ID stage.
- Takes the current fetch address and chip-enable from the PC register and issues single-outstanding requests on a req/ack instruction-memory bus.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to ID with a valid/ready handshake.
- Raises a stall request to the control module so the PC register advances only when its address has been accepted; flushes on a taken branch.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 32, instruction address width.
- IW, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- pc_i  in  AW  current fetch address from the PC register.
- pc_ce_i  in  1  PC register chip-enable; 0 means fetch is inactive.
- flush_i  in  1  branch taken in ID; discard buffered and in-flight fetches.
- stallreq_o  out  1  1 = PC register must hold (drives stall[0] request to control).
- mem_req_o  out  1  memory request, registered.
- mem_addr_o  out  AW  request address, registered, stable while mem_req_o=1.
- mem_ack_i  in  1  memory acknowledge; mem_data_i valid in the same cycle.
- mem_data_i  in  IW  instruction word.
- id_valid_o  out  1  head entry valid to ID.
- id_ready_i  in  1  ID accepts the head entry (low when ID is stalled).
- id_pc_o  out  AW  head pc.
- id_inst_o  out  IW  head instruction; 0 (nop) when id_valid_o=0.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; FIFO empty (count=0, pointers 0).
  - mem_req_o=0, mem_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
  - stallreq_o=1 for as long as rst is asserted.
  - Reset mid-transaction abandons it; memory must tolerate a dropped request.
- FSM states: IDLE, WAIT (request outstanding, data wanted), DISCARD (request outstanding, data to be dropped).
- space:
  - In IDLE: count<DEPTH.
  - In WAIT with mem_ack_i=1: count<DEPTH-1.
  - A same-cycle pop is ignored (conservative).
- issue = pc_ce_i & ~flush_i & space & (state==IDLE | (state∈{WAIT,DISCARD} & mem_ack_i)).
- On issue: next state=WAIT, mem_req_o<=1, mem_addr_o<=pc_i.
- stallreq_o = ~issue & ~flush_i. This is combinational. The PC advances exactly in the cycle its address is captured.
- Flush cycle: stallreq_o=0 so the PC loads the branch target; the sequential pc_i of that cycle is never fetched.
- WAIT, mem_ack_i=1, flush_i=0: push {mem_addr_o, mem_data_i}. Next state is WAIT if issue, else IDLE with mem_req_o<=0.
- WAIT, mem_ack_i=0: hold req and addr.
- WAIT, flush_i=1, mem_ack_i=1: drop data, go to IDLE, mem_req_o<=0.
- WAIT, flush_i=1, mem_ack_i=0: go to DISCARD; req stays high (bus rule: req held until ack).
- DISCARD, mem_ack_i=1: drop data, then go to WAIT if issue, else IDLE. A flush while in DISCARD keeps the state DISCARD.
- flush_i=1 clears the FIFO (count<=0, rd_ptr<=wr_ptr) with priority over push and pop.
- Pop: id_valid_o & id_ready_i & ~flush_i.
- Output timing: id_valid_o = (count!=0). Head fields are read combinationally from the FIFO.
- Minimum latency: pc_i captured at edge N → mem_req_o at N+1 → ack in that cycle → id_valid_o after edge N+2.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count unchanged.
- Push when full cannot occur; the bench asserts this.
- pc_ce_i=0: no issue, stallreq_o=1; any outstanding request completes normally.

Optional Feature:
- Macro IF_BYPASS_EN.
- Defined: when count==0, state==WAIT, mem_ack_i=1 and flush_i=0:
  - id_valid_o=1 and id_pc_o/id_inst_o come combinationally from mem_addr_o/mem_data_i.
  - If id_ready_i=1 the entry is not pushed; otherwise it is pushed.
  - Latency drops by one cycle.
- Undefined: outputs come from the FIFO only.

Decomposition:
- Shared defines header: InstAddrBus, InstBus, ZeroWord, RstEnable, ChipEnable/ChipDisable, Stop/NoStop, and fetch FSM state encodings (IF_IDLE, IF_WAIT, IF_DISCARD).
- One sub-module: fetch_fifo, a DEPTH x (AW+IW) synchronous FIFO with push, pop, clear, count, and combinational head.

Test Plan:
- Zero-wait memory (ack the cycle after req), id_ready_i=1, PC from 0x0 → mem_addr_o 0x0,0x4,0x8 back-to-back; id_pc_o 0x0,0x4,0x8 in consecutive cycles; stallreq_o=0 throughout after startup.
- id_ready_i=0 with DEPTH=4 → exactly 4 entries (0x0..0xC) buffered, no 5th issue, stallreq_o=1, pc_i held at 0x10; raise ready → 0x0..0xC drain in order and fetch resumes at 0x10.
- Memory with 3-cycle ack latency → mem_addr_o stable 3 cycles; stallreq_o=1 in the wait cycles; each instruction appears once.
- flush_i while a request for 0x20 is outstanding and unacked → state DISCARD, req held, data dropped on ack; next fetch is the target 0x100; FIFO empty after flush.
- flush_i in the same cycle as ack and pop → nothing pushed, nothing popped; count=0; stallreq_o=0 in that cycle.
- rst asserted mid-WAIT → next edge: mem_req_o=0, id_valid_o=0, id_inst_o=0; after release, fetch restarts at pc_i=0x0.
